// File: rtl/axis_width_converter_if.sv
// AXI4-Stream bundle used on both sides of axis_width_converter.
// The data/keep width is set per instance; the sideband widths default to the converter's.
interface axis_width_converter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 1
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [ID_WIDTH-1:0]     tid;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [USER_WIDTH-1:0]   tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
   modport slave  (input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_width_converter.sv
// AXI4-Stream integer-ratio width converter: upsize, downsize or equal-width register slice.
// Optional AXIS_WCONV_SIDEBAND_EN carries tid/tdest/tuser; otherwise they are driven to 0.
module axis_width_converter #(
   parameter int S_DATA_WIDTH = 32,
   parameter int M_DATA_WIDTH = 128,
   parameter int ID_WIDTH     = 4,
   parameter int DEST_WIDTH   = 4,
   parameter int USER_WIDTH   = 1
)(
   input  logic                   aclk,
   input  logic                   areset_n,
   axis_width_converter_if.slave  s_axis,
   axis_width_converter_if.master m_axis
);
   localparam int SK = S_DATA_WIDTH / 8;
   localparam int MK = M_DATA_WIDTH / 8;

   if ((S_DATA_WIDTH % 8) != 0 || (M_DATA_WIDTH % 8) != 0) begin : g_err_byte
      $error("axis_width_converter: data widths must be multiples of 8");
   end
   if ((S_DATA_WIDTH > M_DATA_WIDTH) ? (S_DATA_WIDTH % M_DATA_WIDTH != 0)
                                     : (M_DATA_WIDTH % S_DATA_WIDTH != 0)) begin : g_err_ratio
      $error("axis_width_converter: larger width must be a multiple of the smaller");
   end

`ifdef AXIS_WCONV_SIDEBAND_EN
   logic [ID_WIDTH-1:0]   w_sb_id;
   logic [DEST_WIDTH-1:0] w_sb_dest;
   logic [USER_WIDTH-1:0] w_sb_user;
   assign m_axis.tid   = w_sb_id;
   assign m_axis.tdest = w_sb_dest;
   assign m_axis.tuser = w_sb_user;
`else
   logic w_unused_sb;
   assign w_unused_sb  = ^{s_axis.tid, s_axis.tdest, s_axis.tuser};
   assign m_axis.tid   = '0;
   assign m_axis.tdest = '0;
   assign m_axis.tuser = '0;
`endif

   if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_up
      localparam int R  = M_DATA_WIDTH / S_DATA_WIDTH;
      localparam int CW = $clog2(R);
      logic [CW-1:0]           r_cnt;
      logic [M_DATA_WIDTH-1:0] r_acc_data, r_tdata, w_word_data;
      logic [MK-1:0]           r_acc_keep, r_tkeep, w_word_keep;
      logic                    r_tvalid, r_tlast;
      logic                    w_s_ready, w_accept, w_close;

      assign w_s_ready = !r_tvalid || m_axis.tready;
      assign w_accept  = s_axis.tvalid && w_s_ready;
      assign w_close   = w_accept && (s_axis.tlast || r_cnt == CW'(R-1));

      // Accumulator is cleared on every close, so lanes above the closing one read as zero
      always_comb begin
         w_word_data = r_acc_data;
         w_word_keep = r_acc_keep;
         for (int l = 0; l < R; l++) begin
            if (r_cnt == CW'(l)) begin
               w_word_data[l*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis.tdata;
               w_word_keep[l*SK +: SK]                     = s_axis.tkeep;
            end
         end
      end

      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            r_cnt      <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
            r_tvalid   <= 1'b0;
         end else begin
            if (m_axis.tready) r_tvalid <= 1'b0;
            if (w_accept) begin
               if (w_close) begin
                  r_cnt      <= '0;
                  r_acc_data <= '0;
                  r_acc_keep <= '0;
                  r_tdata    <= w_word_data;
                  r_tkeep    <= w_word_keep;
                  r_tlast    <= s_axis.tlast;
                  r_tvalid   <= 1'b1;
               end else begin
                  r_cnt      <= r_cnt + 1'b1;
                  r_acc_data <= w_word_data;
                  r_acc_keep <= w_word_keep;
               end
            end
         end
      end

`ifdef AXIS_WCONV_SIDEBAND_EN
      logic [ID_WIDTH-1:0]   r_acc_id, r_tid, w_id;
      logic [DEST_WIDTH-1:0] r_acc_dest, r_tdest, w_dest;
      logic [USER_WIDTH-1:0] r_acc_user, r_tuser, w_user;
      assign w_id   = (r_cnt == '0) ? s_axis.tid   : r_acc_id;
      assign w_dest = (r_cnt == '0) ? s_axis.tdest : r_acc_dest;
      assign w_user = r_acc_user | s_axis.tuser;
      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            {r_acc_id, r_acc_dest, r_acc_user, r_tid, r_tdest, r_tuser} <= '0;
         end else if (w_accept) begin
            if (w_close) begin
               r_tid      <= w_id;
               r_tdest    <= w_dest;
               r_tuser    <= w_user;
               r_acc_user <= '0;
            end else begin
               r_acc_id   <= w_id;
               r_acc_dest <= w_dest;
               r_acc_user <= w_user;
            end
         end
      end
      assign w_sb_id   = r_tid;
      assign w_sb_dest = r_tdest;
      assign w_sb_user = r_tuser;
`endif

      assign s_axis.tready = w_s_ready;
      assign m_axis.tvalid = r_tvalid;
      assign m_axis.tdata  = r_tdata;
      assign m_axis.tkeep  = r_tkeep;
      assign m_axis.tlast  = r_tlast;
   end else if (S_DATA_WIDTH > M_DATA_WIDTH) begin : g_down
      localparam int R  = S_DATA_WIDTH / M_DATA_WIDTH;
      localparam int CW = $clog2(R);
      logic [S_DATA_WIDTH-1:0] r_hold_data;
      logic [SK-1:0]           r_hold_keep;
      logic                    r_hold_last, r_busy;
      logic [CW-1:0]           r_lane, r_last, w_last;
      logic                    w_lane_end, w_s_ready, w_accept;

      assign w_lane_end = (r_lane == r_last);
      assign w_s_ready  = !r_busy || (w_lane_end && m_axis.tready);
      assign w_accept   = s_axis.tvalid && w_s_ready;

      // A closing word stops at its highest populated lane; an all-empty one still emits lane 0
      always_comb begin
         w_last = CW'(R-1);
         if (s_axis.tlast) begin
            w_last = '0;
            for (int l = 0; l < R; l++)
               if (|s_axis.tkeep[l*MK +: MK]) w_last = CW'(l);
         end
      end

      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            r_hold_data <= '0;
            r_hold_keep <= '0;
            r_hold_last <= 1'b0;
            r_busy      <= 1'b0;
            r_lane      <= '0;
            r_last      <= '0;
         end else if (w_accept) begin
            r_hold_data <= s_axis.tdata;
            r_hold_keep <= s_axis.tkeep;
            r_hold_last <= s_axis.tlast;
            r_busy      <= 1'b1;
            r_lane      <= '0;
            r_last      <= w_last;
         end else if (r_busy && m_axis.tready) begin
            if (w_lane_end) r_busy <= 1'b0;
            else            r_lane <= r_lane + 1'b1;
         end
      end

`ifdef AXIS_WCONV_SIDEBAND_EN
      logic [ID_WIDTH-1:0]   r_tid;
      logic [DEST_WIDTH-1:0] r_tdest;
      logic [USER_WIDTH-1:0] r_tuser;
      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            {r_tid, r_tdest, r_tuser} <= '0;
         end else if (w_accept) begin
            r_tid   <= s_axis.tid;
            r_tdest <= s_axis.tdest;
            r_tuser <= s_axis.tuser;
         end
      end
      assign w_sb_id   = r_tid;
      assign w_sb_dest = r_tdest;
      assign w_sb_user = r_tuser;
`endif

      assign s_axis.tready = w_s_ready;
      assign m_axis.tvalid = r_busy;
      assign m_axis.tdata  = r_hold_data[r_lane*M_DATA_WIDTH +: M_DATA_WIDTH];
      assign m_axis.tkeep  = r_hold_keep[r_lane*MK +: MK];
      assign m_axis.tlast  = r_hold_last && w_lane_end;
   end else begin : g_eq
      logic [S_DATA_WIDTH-1:0] r_tdata;
      logic [SK-1:0]           r_tkeep;
      logic                    r_tvalid, r_tlast;
      logic                    w_s_ready, w_accept;

      assign w_s_ready = !r_tvalid || m_axis.tready;
      assign w_accept  = s_axis.tvalid && w_s_ready;

      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
         end else if (w_accept) begin
            r_tdata  <= s_axis.tdata;
            r_tkeep  <= s_axis.tkeep;
            r_tlast  <= s_axis.tlast;
            r_tvalid <= 1'b1;
         end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
         end
      end

`ifdef AXIS_WCONV_SIDEBAND_EN
      logic [ID_WIDTH-1:0]   r_tid;
      logic [DEST_WIDTH-1:0] r_tdest;
      logic [USER_WIDTH-1:0] r_tuser;
      always_ff @(posedge aclk) begin
         if (!areset_n) begin
            {r_tid, r_tdest, r_tuser} <= '0;
         end else if (w_accept) begin
            r_tid   <= s_axis.tid;
            r_tdest <= s_axis.tdest;
            r_tuser <= s_axis.tuser;
         end
      end
      assign w_sb_id   = r_tid;
      assign w_sb_dest = r_tdest;
      assign w_sb_user = r_tuser;
`endif

      assign s_axis.tready = w_s_ready;
      assign m_axis.tvalid = r_tvalid;
      assign m_axis.tdata  = r_tdata;
      assign m_axis.tkeep  = r_tkeep;
      assign m_axis.tlast  = r_tlast;
   end
endmodule
